// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversampled pads, MSB-first rx/tx words; pad-to-event latency SYNC_STAGES+1 clk.
// rx has no backpressure (rx_data held until next word); tx via a one-word valid/ready holding register.
module spi_slave_if #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              busy,
   output logic              frame_end
);
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic [SYNC_STAGES:0]   flush;
   logic                   armed;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   got_bit;
   logic [DATA_W-1:0]      rx_shift, tx_shift, hold;
   logic                   hold_full;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = armed & ~cs_s & cs_d;

   assign busy     = (state == SHIFT);
   assign miso     = (state == SHIFT) & tx_shift[DATA_W-1];
   assign tx_ready = ~hold_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         flush     <= '0;
         armed     <= 1'b0;
         state     <= IDLE;
         bit_cnt   <= '0;
         got_bit   <= 1'b0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
         rx_valid  <= 1'b0;
         frame_end <= 1'b0;

         // A cs_n held low through reset must be seen high once before a frame may start.
         if (flush[SYNC_STAGES] && cs_s)
            armed <= 1'b1;

         if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  got_bit  <= 1'b0;
                  rx_shift <= '0;
                  tx_shift <= hold_full ? hold : '0;
                  if (hold_full)
                     hold_full <= 1'b0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state     <= IDLE;
                  frame_end <= 1'b1;
                  bit_cnt   <= '0;
                  got_bit   <= 1'b0;
                  rx_shift  <= '0;
                  tx_shift  <= '0;
               end else if (sclk_rise) begin
                  rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                  got_bit  <= 1'b1;
                  if (bit_cnt == CNT_W'(DATA_W-1)) begin
                     rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
                     rx_valid <= 1'b1;
                     bit_cnt  <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (sclk_fall) begin
                  if (bit_cnt != '0) begin
                     tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  end else if (got_bit) begin
                     // Word boundary: next word from holding register, zeros on underrun.
                     tx_shift <= hold_full ? hold : '0;
                     if (hold_full)
                        hold_full <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: vector table of whole frames plus hand-written reset/back-to-back sequences.
module tb_spi_slave_if;
   localparam int H = 6;

   logic       clk, rst, sclk, cs_n, mosi, miso;
   logic [7:0] rx_data, tx_data;
   logic       rx_valid, tx_valid, tx_ready, busy, frame_end;

   spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_end(frame_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] rx_q[$];
   int         fe_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (frame_end) fe_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tx_load(input logic [7:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (tx_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
   endtask

   task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] m);
      m = '0;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = w[i];
         repeat (H) @(negedge clk);
         m    = {m[14:0], miso};
         sclk = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   typedef struct {
      string       name;
      logic [15:0] mosi_w;
      int          nbits;
      bit          load_tx;
      logic [7:0]  tx_w;
      logic [15:0] exp_miso;
      int          exp_rx_cnt;
      logic [7:0]  exp_rx_data;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [15:0] m;
      bit          ok;
      int          fe0;

      vecs[0] = '{"single_rx",   16'h00A5, 8, 1'b0, 8'h00, 16'h0000, 1, 8'hA5};
      vecs[1] = '{"full_duplex", 16'h005A, 8, 1'b1, 8'h3C, 16'h003C, 1, 8'h5A};
      vecs[2] = '{"abort5",      16'h0016, 5, 1'b0, 8'h00, 16'h0000, 0, 8'h5A};
      vecs[3] = '{"underrun",    16'h00FF, 8, 1'b0, 8'h00, 16'h0000, 1, 8'hFF};
      vecs[4] = '{"tx_ones",     16'h0000, 8, 1'b1, 8'hFF, 16'h00FF, 1, 8'h00};

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         sclk = 1'($urandom); cs_n = 1'($urandom); mosi = 1'($urandom);
      end
      @(negedge clk);
      check("rst_miso", 32'(miso), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_tx_ready", 32'(tx_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      rst = 1'b0;
      repeat (10) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         rx_q.delete();
         fe0 = fe_cnt;
         if (vecs[v].load_tx) begin
            tx_load(vecs[v].tx_w, ok);
            check({vecs[v].name, "_load"}, 32'(ok), 1);
            check({vecs[v].name, "_tx_ready_low"}, 32'(tx_ready), 0);
         end
         spi_frame(vecs[v].mosi_w, vecs[v].nbits, m);
         check({vecs[v].name, "_miso"}, 32'(m), 32'(vecs[v].exp_miso));
         check({vecs[v].name, "_rx_cnt"}, 32'(rx_q.size()), 32'(vecs[v].exp_rx_cnt));
         if (rx_q.size() > 0)
            check({vecs[v].name, "_rx_word"}, 32'(rx_q[0]), 32'(vecs[v].exp_rx_data));
         check({vecs[v].name, "_rx_data"}, 32'(rx_data), 32'(vecs[v].exp_rx_data));
         check({vecs[v].name, "_frame_end"}, 32'(fe_cnt - fe0), 1);
         check({vecs[v].name, "_busy"}, 32'(busy), 0);
         check({vecs[v].name, "_tx_ready"}, 32'(tx_ready), 1);
      end

      // Back-to-back words with a reload during the first word.
      rx_q.delete();
      tx_load(8'h81, ok);
      check("b2b_load1", 32'(ok), 1);
      check("b2b_tx_ready_low", 32'(tx_ready), 0);
      fork
         spi_frame(16'h1122, 16, m);
         begin
            repeat (30) @(negedge clk);
            check("b2b_tx_ready_mid", 32'(tx_ready), 1);
            tx_load(8'h7E, ok);
            check("b2b_load2", 32'(ok), 1);
         end
      join
      check("b2b_miso", 32'(m), 32'h817E);
      check("b2b_rx_cnt", 32'(rx_q.size()), 2);
      if (rx_q.size() == 2) begin
         check("b2b_rx0", 32'(rx_q[0]), 32'h11);
         check("b2b_rx1", 32'(rx_q[1]), 32'h22);
      end
      check("b2b_tx_ready", 32'(tx_ready), 1);

      // Reset in the middle of a frame, then a clean frame.
      rx_q.delete();
      fe0 = fe_cnt;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 7; i >= 5; i--) begin
         mosi = i[0];
         repeat (H) @(negedge clk);
         sclk = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
      check("midrst_busy_before", 32'(busy), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_miso", 32'(miso), 0);
      check("midrst_rx_data", 32'(rx_data), 0);
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (12) @(negedge clk);
      check("midrst_no_rx", 32'(rx_q.size()), 0);
      check("midrst_no_fe", 32'(fe_cnt - fe0), 0);
      spi_frame(16'h00C3, 8, m);
      check("after_rst_rx_cnt", 32'(rx_q.size()), 1);
      check("after_rst_rx_data", 32'(rx_data), 32'hC3);
      check("after_rst_fe", 32'(fe_cnt - fe0), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
